// File: rtl/var_delay_line.sv
// var_delay_line: runtime-programmable valid-tagged delay line with stall, flush and in-flight count
module var_delay_line #(
    parameter int N             = 4,
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 2,
    parameter int SEL_W         = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [SEL_W-1:0] delay_sel,
    input  logic             ivalid,
    input  logic [N-1:0]     idata,
    output logic             ovalid,
    output logic [N-1:0]     odata,
    output logic [SEL_W-1:0] inflight,
    output logic             sel_err
);
    logic [MAX_DELAY:1] r_v;
    logic [N-1:0]       r_d [1:MAX_DELAY];
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_req;
    logic [MAX_DELAY:0] w_v;
    logic [N-1:0]       w_d [0:MAX_DELAY];

    assign sel_err = delay_sel > SEL_W'(MAX_DELAY);
    assign w_req   = sel_err ? SEL_W'(MAX_DELAY) : delay_sel;
    assign w_v     = {r_v, ivalid};
    assign ovalid  = w_v[r_sel];
    assign odata   = ovalid ? w_d[r_sel] : '0;

    // tap view: index 0 is the live input (zero-delay bypass), index k is stage k
    always_comb begin
        w_d[0] = idata;
        for (int k = 1; k <= MAX_DELAY; k++) w_d[k] = r_d[k];
    end

    // count valid samples only within the active delay window
    always_comb begin
        inflight = '0;
        for (int k = 1; k <= MAX_DELAY; k++)
            if (SEL_W'(k) <= r_sel && r_v[k]) inflight = inflight + SEL_W'(1);
    end

    // stage shifting with flush, reprogram-discard and stall, flush taking precedence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= '0;
            for (int k = 1; k <= MAX_DELAY; k++) r_d[k] <= '0;
            r_sel <= SEL_W'(DEFAULT_DELAY);
        end else if (flush) begin
            r_v   <= '0;
            for (int k = 1; k <= MAX_DELAY; k++) r_d[k] <= '0;
            r_sel <= w_req;
        end else if (w_req != r_sel) begin
            r_sel <= w_req;
            r_v   <= '0;
            for (int k = 2; k <= MAX_DELAY; k++) r_d[k] <= '0;
            r_v[1] <= ce & ivalid;
            r_d[1] <= ce ? idata : '0;
        end else if (ce) begin
            r_v[1] <= ivalid;
            r_d[1] <= idata;
            for (int k = 2; k <= MAX_DELAY; k++) begin
                r_v[k] <= r_v[k-1];
                r_d[k] <= r_d[k-1];
            end
        end
    end
endmodule
